i2c_cmd_sequencer: RTL and testbench
====================================

I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: command FIFO entries; power of 2, range 2..16.
REQ-002 Parameter ACCEPT_TIMEOUT, default 64: max I2C_clock cycles in ISSUE waiting for m_busy=1.
REQ-003 Parameter DONE_TIMEOUT, default 1024: max I2C_clock cycles in WAIT_DONE waiting for m_busy=0.
REQ-004 I2C_clock  in  1  block clock, same clock driving the I2C master.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  FIFO can accept a command.
REQ-008 cmd_addr  in  7  target I2C address.
REQ-009 cmd_rw  in  1  0 = write, 1 = read.
REQ-010 cmd_data  in  16  write payload, ignored for reads.
REQ-011 flush  in  1  discard all queued, not-yet-issued commands.
REQ-012 m_ena, m_addr[6:0], m_rw, m_data_wr[15:0]  out  master request bus.
REQ-013 m_busy  in  1  master busy flag.
REQ-014 m_data_rd  in  16  master read data.
REQ-015 m_ack_error  in  1  master ack-error flag.
REQ-016 rsp_valid  out  1  one-cycle completion strobe.
REQ-017 rsp_addr[6:0], rsp_rw, rsp_data[15:0], rsp_ack_error, rsp_timeout  out  completion record.
REQ-018 fifo_count  out  5  queued entries, excluding the in-flight command.
REQ-019 seq_busy  out  1  high whenever state != IDLE.

Function
REQ-020 Push accepted on the rising edge where cmd_valid=1 and cmd_ready=1; cmd_ready = (fifo_count < FIFO_DEPTH), from registered count only.
REQ-021 Push while full: not accepted, FIFO unchanged, no error flag.
REQ-022 Simultaneous push and pop: both occur; count unchanged; full-FIFO push still refused that cycle.
REQ-023 Pointers wrap modulo FIFO_DEPTH; FIFO order strictly preserved.
REQ-024 flush: count and pointers cleared next edge; in-flight command unaffected; flush wins over a same-cycle push.
REQ-025 States: IDLE, ISSUE, WAIT_DONE, RESPOND.
REQ-026 IDLE: FIFO non-empty and m_busy=0 -> pop head into the m_addr/m_rw/m_data_wr registers, m_ena<=1, go to ISSUE.
REQ-027 ISSUE: m_busy=1 -> m_ena<=0, go to WAIT_DONE; timer reaches ACCEPT_TIMEOUT -> m_ena<=0, rsp_timeout<=1, go to RESPOND.
REQ-028 WAIT_DONE: m_busy=0 -> latch m_data_rd into rsp_data and m_ack_error into rsp_ack_error, rsp_timeout<=0, go to RESPOND; timer reaches DONE_TIMEOUT -> rsp_timeout<=1, rsp_data<=0, go to RESPOND.
REQ-029 RESPOND: rsp_valid=1 for exactly one cycle, then IDLE; the next pop occurs no earlier than the cycle after RESPOND.
REQ-030 Timer: 16-bit, cleared on every state entry, saturating.
REQ-031 m_addr, m_rw, m_data_wr held stable from ISSUE entry until the next pop.
REQ-032 rsp_addr and rsp_rw are copies of the issued command; rsp_data, rsp_ack_error, rsp_addr, rsp_rw and rsp_timeout hold their values until the next RESPOND.
REQ-033 For write commands rsp_data = m_data_rd as latched, with no masking.
REQ-034 m_busy=1 in IDLE (master in reset or busy): no pop.

Reset
REQ-035 Asynchronous assertion resets all state in any state, including mid-transaction; no response is generated for the aborted command.
REQ-036 Reset values: state IDLE; FIFO empty; fifo_count 0; cmd_ready 1; m_ena 0; m_addr, m_rw, m_data_wr 0; rsp_valid 0; rsp_* 0; seq_busy 0.
REQ-037 Deassertion takes effect on the first I2C_clock rising edge after reset_n goes high.

Verification
REQ-038 Single write: push addr=0x20, rw=0, data=0xA5C3; master model raises busy 3 cycles after m_ena and drops it 100 cycles later -> m_ena high until busy is seen, one rsp_valid with rsp_addr=0x20, rsp_rw=0, rsp_ack_error=0, rsp_timeout=0.
REQ-039 Read: push addr=0x48, rw=1; model returns m_data_rd=0x1234 with m_ack_error=1 -> rsp_data=0x1234, rsp_ack_error=1.
REQ-040 Full FIFO: hold master busy, push 6 commands -> 4 queued plus 1 in flight, 6th refused, cmd_ready=0; after release, 5 responses in push order.
REQ-041 Accept timeout: m_busy held 0 -> after 64 cycles in ISSUE, m_ena=0 and rsp_valid with rsp_timeout=1; the next queued command is then issued.
REQ-042 Flush plus reset: 3 queued, flush -> fifo_count=0 and only the in-flight command responds; reset_n low during WAIT_DONE -> all outputs at reset values, no rsp_valid.

Source files
------------

// File: rtl/i2c_cmd_sequencer.sv
// Command FIFO plus issue/complete sequencer in front of a simple I2C master.
// Pops one command at a time, waits for the master and returns a completion record.
module i2c_cmd_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int ACCEPT_TIMEOUT = 64,
    parameter int DONE_TIMEOUT   = 1024
) (
    input  logic        I2C_clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd_addr,
    input  logic        cmd_rw,
    input  logic [15:0] cmd_data,
    input  logic        flush,
    output logic        m_ena,
    output logic [6:0]  m_addr,
    output logic        m_rw,
    output logic [15:0] m_data_wr,
    input  logic        m_busy,
    input  logic [15:0] m_data_rd,
    input  logic        m_ack_error,
    output logic        rsp_valid,
    output logic [6:0]  rsp_addr,
    output logic        rsp_rw,
    output logic [15:0] rsp_data,
    output logic        rsp_ack_error,
    output logic        rsp_timeout,
    output logic [4:0]  fifo_count,
    output logic        seq_busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0]  DEPTH5   = 5'(FIFO_DEPTH);
    localparam logic [15:0] ACC_LIM  = 16'(ACCEPT_TIMEOUT - 1);
    localparam logic [15:0] DONE_LIM = 16'(DONE_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESPOND} state_t;

    state_t         state, state_d;
    logic [23:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [4:0]     count;
    logic [15:0]    timer, timer_d;
    logic           push, pop;
    logic [23:0]    head;

    logic           m_ena_d, m_rw_d, rsp_rw_d, rsp_ack_d, rsp_to_d;
    logic [6:0]     m_addr_d, rsp_addr_d;
    logic [15:0]    m_data_wr_d, rsp_data_d;

    assign cmd_ready  = (count < DEPTH5);
    assign push       = cmd_valid && cmd_ready && !flush;
    assign pop        = (state == IDLE) && (count != 5'd0) && !m_busy;
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    assign seq_busy   = (state != IDLE);
    assign rsp_valid  = (state == RESPOND);

    always_ff @(posedge I2C_clock) begin
        if (push)
            mem[wr_ptr] <= {cmd_addr, cmd_rw, cmd_data};
    end

    // flush only clears the queue; a command already popped keeps running
    always_ff @(posedge I2C_clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {4'd0, push} - {4'd0, pop};
        end
    end

    always_comb begin
        state_d     = state;
        m_ena_d     = m_ena;
        m_addr_d    = m_addr;
        m_rw_d      = m_rw;
        m_data_wr_d = m_data_wr;
        rsp_addr_d  = rsp_addr;
        rsp_rw_d    = rsp_rw;
        rsp_data_d  = rsp_data;
        rsp_ack_d   = rsp_ack_error;
        rsp_to_d    = rsp_timeout;
        unique case (state)
            IDLE: begin
                if (pop) begin
                    state_d = ISSUE;
                    m_ena_d = 1'b1;
                    {m_addr_d, m_rw_d, m_data_wr_d} = head;
                end
            end
            ISSUE: begin
                if (m_busy) begin
                    state_d = WAIT_DONE;
                    m_ena_d = 1'b0;
                end else if (timer >= ACC_LIM) begin
                    state_d    = RESPOND;
                    m_ena_d    = 1'b0;
                    rsp_to_d   = 1'b1;
                    rsp_data_d = '0;
                    rsp_ack_d  = 1'b0;
                end
            end
            WAIT_DONE: begin
                if (!m_busy) begin
                    state_d    = RESPOND;
                    rsp_data_d = m_data_rd;
                    rsp_ack_d  = m_ack_error;
                    rsp_to_d   = 1'b0;
                end else if (timer >= DONE_LIM) begin
                    state_d    = RESPOND;
                    rsp_to_d   = 1'b1;
                    rsp_data_d = '0;
                    rsp_ack_d  = 1'b0;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == RESPOND && state != RESPOND) begin
            rsp_addr_d = m_addr;
            rsp_rw_d   = m_rw;
        end
        if (state_d != state)
            timer_d = '0;
        else if (timer == 16'hFFFF)
            timer_d = timer;
        else
            timer_d = timer + 16'd1;
    end

    always_ff @(posedge I2C_clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            timer         <= '0;
            m_ena         <= 1'b0;
            m_addr        <= '0;
            m_rw          <= 1'b0;
            m_data_wr     <= '0;
            rsp_addr      <= '0;
            rsp_rw        <= 1'b0;
            rsp_data      <= '0;
            rsp_ack_error <= 1'b0;
            rsp_timeout   <= 1'b0;
        end else begin
            state         <= state_d;
            timer         <= timer_d;
            m_ena         <= m_ena_d;
            m_addr        <= m_addr_d;
            m_rw          <= m_rw_d;
            m_data_wr     <= m_data_wr_d;
            rsp_addr      <= rsp_addr_d;
            rsp_rw        <= rsp_rw_d;
            rsp_data      <= rsp_data_d;
            rsp_ack_error <= rsp_ack_d;
            rsp_timeout   <= rsp_to_d;
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: directed vector table, corner sequences and
// randomized traffic against a queue-based model of the command stream.
module tb_i2c_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int ACC_TO = 64;
    localparam int DONE_TO = 1024;

    typedef struct packed {
        logic [6:0]  addr;
        logic        rw;
        logic [15:0] data;
    } cmd_t;

    typedef struct {
        cmd_t c;
        bit   acc_to;
        int   t0;
    } inf_t;

    typedef struct packed {
        logic [15:0] data;
        logic        ack;
        logic        to;
    } out_t;

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        logic [15:0] data;
        logic        ack;
        logic        to;
        int          delta;
    } log_t;

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        ack;
        int          acc;
        int          blen;
        logic [15:0] exp_data;
        logic        exp_ack;
        logic        exp_to;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_addr;
    logic        cmd_rw;
    logic [15:0] cmd_data;
    logic        flush;
    logic        m_ena;
    logic [6:0]  m_addr;
    logic        m_rw;
    logic [15:0] m_data_wr;
    logic        m_busy;
    logic [15:0] m_data_rd;
    logic        m_ack_error;
    logic        rsp_valid;
    logic [6:0]  rsp_addr;
    logic        rsp_rw;
    logic [15:0] rsp_data;
    logic        rsp_ack_error;
    logic        rsp_timeout;
    logic [4:0]  fifo_count;
    logic        seq_busy;

    i2c_cmd_sequencer #(
        .FIFO_DEPTH(DEPTH),
        .ACCEPT_TIMEOUT(ACC_TO),
        .DONE_TIMEOUT(DONE_TO)
    ) dut (
        .I2C_clock(clk),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr),
        .cmd_rw(cmd_rw),
        .cmd_data(cmd_data),
        .flush(flush),
        .m_ena(m_ena),
        .m_addr(m_addr),
        .m_rw(m_rw),
        .m_data_wr(m_data_wr),
        .m_busy(m_busy),
        .m_data_rd(m_data_rd),
        .m_ack_error(m_ack_error),
        .rsp_valid(rsp_valid),
        .rsp_addr(rsp_addr),
        .rsp_rw(rsp_rw),
        .rsp_data(rsp_data),
        .rsp_ack_error(rsp_ack_error),
        .rsp_timeout(rsp_timeout),
        .fifo_count(fifo_count),
        .seq_busy(seq_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int tnow = 0;
    int rsp_cnt = 0;

    cmd_t q[$];
    inf_t inflight[$];
    out_t outc[$];
    log_t rsp_log[$];

    bit   prev_ena = 0;
    bit   rdy_pred = 1;
    bit   drv_valid = 0;
    bit   drv_flush = 0;
    cmd_t drv_cmd = '0;

    bit          accept_en = 1;
    bit          rand_mode = 0;
    int          acc_dly = 1;
    int          busy_len = 4;
    logic [15:0] rd_val = '0;
    logic        ack_val = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // behavioural master: accepts after acc_dly cycles, stays busy busy_len cycles
    initial begin
        int d, b;
        out_t o;
        m_busy = 0;
        m_data_rd = '0;
        m_ack_error = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && m_ena && accept_en) begin
                d = acc_dly;
                b = busy_len;
                o.data = rand_mode ? 16'($urandom) : rd_val;
                o.ack = rand_mode ? 1'($urandom) : ack_val;
                o.to = (b > DONE_TO);
                repeat (d - 1) @(posedge clk);
                if (d > 1) #1;
                m_busy = 1;
                outc.push_back(o);
                repeat (b) @(posedge clk);
                #1;
                m_data_rd = o.data;
                m_ack_error = o.ack;
                m_busy = 0;
            end
        end
    end

    task automatic drive(bit v, cmd_t c, bit f);
        drv_valid = v;
        drv_cmd = c;
        drv_flush = f;
        cmd_valid = v;
        cmd_addr = c.addr;
        cmd_rw = c.rw;
        cmd_data = c.data;
        flush = f;
    endtask

    task automatic tick();
        inf_t r;
        out_t o;
        log_t l;
        @(negedge clk);
        tnow++;
        if (!reset_n) begin
            prev_ena = 0;
            return;
        end
        if (m_ena && !prev_ena) begin
            chk("pop_from_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                chk("issue_cmd", {m_addr, m_rw, m_data_wr}, q[0]);
                r.c = q.pop_front();
                r.acc_to = !accept_en;
                r.t0 = tnow;
                inflight.push_back(r);
            end
        end
        prev_ena = m_ena;
        if (drv_flush)
            q.delete();
        else if (drv_valid && rdy_pred)
            q.push_back(drv_cmd);
        chk("seq_busy", seq_busy, inflight.size() != 0);
        if (rsp_valid) begin
            chk("rsp_has_cmd", inflight.size() != 0, 1);
            if (inflight.size() != 0) begin
                r = inflight.pop_front();
                chk("rsp_cmd", {rsp_addr, rsp_rw}, {r.c.addr, r.c.rw});
                chk("rsp_ena_low", m_ena, 0);
                if (r.acc_to) begin
                    chk("rsp_accept_to", rsp_timeout, 1);
                end else begin
                    chk("rsp_outcome", outc.size() != 0, 1);
                    if (outc.size() != 0) begin
                        o = outc.pop_front();
                        if (o.to)
                            chk("rsp_done_to", {rsp_timeout, rsp_data}, {1'b1, 16'h0});
                        else
                            chk("rsp_done", {rsp_timeout, rsp_ack_error, rsp_data},
                                {1'b0, o.ack, o.data});
                    end
                end
                l.addr = rsp_addr;
                l.rw = rsp_rw;
                l.data = rsp_data;
                l.ack = rsp_ack_error;
                l.to = rsp_timeout;
                l.delta = tnow - r.t0;
                rsp_log.push_back(l);
                rsp_cnt++;
            end
        end
        chk("fifo_count", fifo_count, q.size());
        chk("cmd_ready", cmd_ready, q.size() < DEPTH);
        rdy_pred = (q.size() < DEPTH);
    endtask

    task automatic idle(int n);
        drive(0, '0, 0);
        repeat (n) tick();
    endtask

    task automatic wait_rsp(int target, int budget, string nm);
        int k = 0;
        drive(0, '0, 0);
        while (rsp_cnt < target && k < budget) begin
            tick();
            k++;
        end
        chk(nm, rsp_cnt >= target, 1);
    endtask

    task automatic wait_quiet(int budget);
        int k = 0;
        drive(0, '0, 0);
        while ((m_busy || seq_busy || q.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        chk("quiet", {m_busy, seq_busy, q.size() != 0}, 3'b000);
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({m_ena, m_addr, m_rw, m_data_wr, rsp_valid, rsp_addr, rsp_rw,
                    rsp_data, rsp_ack_error, rsp_timeout, fifo_count, cmd_ready, seq_busy});
    endfunction

    vec_t vt[5];
    cmd_t c;
    int base;

    initial begin
        vt[0] = '{7'h20, 1'b0, 16'hA5C3, 16'h5A5A, 1'b0, 3, 100,  16'h5A5A, 1'b0, 1'b0};
        vt[1] = '{7'h48, 1'b1, 16'h0000, 16'h1234, 1'b1, 2, 20,   16'h1234, 1'b1, 1'b0};
        vt[2] = '{7'h7F, 1'b0, 16'hFFFF, 16'hBEEF, 1'b0, 1, 5,    16'hBEEF, 1'b0, 1'b0};
        vt[3] = '{7'h00, 1'b1, 16'h0000, 16'hFFFF, 1'b1, 4, 1,    16'hFFFF, 1'b1, 1'b0};
        vt[4] = '{7'h33, 1'b0, 16'h1357, 16'h2468, 1'b1, 2, 1100, 16'h0000, 1'b0, 1'b1};

        reset_n = 0;
        drive(0, '0, 0);
        repeat (3) @(negedge clk);
        chk("reset_state", out_vec(), 64'h2);
        reset_n = 1;
        idle(2);

        foreach (vt[i]) begin
            wait_quiet(2000);
            rand_mode = 0;
            acc_dly = vt[i].acc;
            busy_len = vt[i].blen;
            rd_val = vt[i].rdata;
            ack_val = vt[i].ack;
            base = rsp_cnt;
            c = '{vt[i].addr, vt[i].rw, vt[i].wdata};
            drive(1, c, 0);
            tick();
            wait_rsp(base + 1, 1500, "vec_rsp_seen");
            chk("vec_addr_rw", {rsp_addr, rsp_rw}, {vt[i].addr, vt[i].rw});
            chk("vec_timeout", rsp_timeout, vt[i].exp_to);
            chk("vec_data", rsp_data, vt[i].exp_data);
            if (!vt[i].exp_to)
                chk("vec_ack", rsp_ack_error, vt[i].exp_ack);
        end

        // full FIFO: one in flight, four queued, sixth refused
        wait_quiet(2000);
        rand_mode = 1;
        acc_dly = 1;
        busy_len = 60;
        rsp_log.delete();
        base = rsp_cnt;
        drive(1, '{7'h10, 1'b0, 16'h0100}, 0);
        tick();
        idle(3);
        for (int k = 1; k < 6; k++) begin
            if (k == 5)
                chk("full_ready_low", cmd_ready, 0);
            drive(1, '{7'(8'h10 + k), 1'(k), 16'(k)}, 0);
            tick();
        end
        chk("full_count", fifo_count, 4);
        wait_rsp(base + 5, 1000, "full_rsp_seen");
        idle(5);
        chk("full_rsp_total", rsp_log.size(), 5);
        foreach (rsp_log[i])
            chk("full_order", rsp_log[i].addr, 7'(8'h10 + i));

        // accept timeout, then next queued command still issued
        wait_quiet(500);
        accept_en = 0;
        rsp_log.delete();
        base = rsp_cnt;
        drive(1, '{7'h51, 1'b1, 16'h0}, 0);
        tick();
        drive(1, '{7'h52, 1'b0, 16'h7777}, 0);
        tick();
        wait_rsp(base + 2, 400, "acc_rsp_seen");
        if (rsp_log.size() == 2) begin
            chk("acc_issue_cycles", rsp_log[0].delta, ACC_TO);
            chk("acc_next_addr", rsp_log[1].addr, 7'h52);
            chk("acc_to_flags", {rsp_log[0].to, rsp_log[1].to}, 2'b11);
        end
        accept_en = 1;

        // flush while three queued: only the in-flight command answers
        wait_quiet(500);
        busy_len = 60;
        rsp_log.delete();
        base = rsp_cnt;
        drive(1, '{7'h61, 1'b0, 16'hAAAA}, 0);
        tick();
        idle(3);
        for (int k = 2; k < 5; k++) begin
            drive(1, '{7'(8'h60 + k), 1'b1, 16'h0}, 0);
            tick();
        end
        chk("flush_pre_count", fifo_count, 3);
        drive(1, '{7'h6F, 1'b0, 16'h0}, 1);
        tick();
        chk("flush_count", fifo_count, 0);
        wait_rsp(base + 1, 300, "flush_rsp_seen");
        idle(30);
        chk("flush_rsp_total", rsp_log.size(), 1);
        chk("flush_rsp_addr", rsp_addr, 7'h61);

        // reset mid-transaction while in WAIT_DONE
        wait_quiet(500);
        busy_len = 200;
        base = rsp_cnt;
        drive(1, '{7'h3C, 1'b1, 16'h0}, 0);
        tick();
        begin
            int k = 0;
            drive(0, '0, 0);
            while (!(m_busy && !m_ena && seq_busy) && k < 50) begin
                tick();
                k++;
            end
            chk("reached_wait_done", {m_busy, m_ena, seq_busy}, 3'b101);
        end
        #2 reset_n = 0;
        #1 chk("async_reset_vals", out_vec(), 64'h2);
        q.delete();
        inflight.delete();
        outc.delete();
        rdy_pred = 1;
        repeat (3) tick();
        chk("held_reset_vals", out_vec(), 64'h2);
        reset_n = 1;
        idle(30);
        chk("no_rsp_after_reset", rsp_cnt, base);
        wait_quiet(500);

        // randomized traffic
        rand_mode = 1;
        for (int t = 0; t < 400; t++) begin
            acc_dly = $urandom_range(1, 4);
            busy_len = $urandom_range(1, 15);
            c = '{7'($urandom), 1'($urandom), 16'($urandom)};
            drive($urandom_range(0, 1) == 1, c, $urandom_range(0, 31) == 0);
            tick();
        end
        begin
            int k = 0;
            drive(0, '0, 0);
            while ((q.size() != 0 || inflight.size() != 0 || m_busy) && k < 3000) begin
                tick();
                k++;
            end
            chk("random_drained", {q.size() != 0, inflight.size() != 0}, 2'b00);
        end
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
